imem_loader: RTL and testbench

Instruction-memory writer that streams a program into the `instr_mem` ROM/RAM from a byte-wide valid/ready source, such as a UART receiver or switch-entry front end. It is the write-side counterpart of the fetch stage's read port. It packs bytes big-endian into 32-bit words, issues one write strobe per word at consecutive word-aligned byte addresses, and holds the CPU pipeline in reset while loading.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_if.sv | 31 +++
 rtl/imem_loader_byte_packer.sv | 31 +++
 rtl/imem_loader.sv | 107 ++++++++++
 tb/tb_imem_loader.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// State encoding is fixed so it reads the same in waveforms across builds.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    localparam logic [1:0] BYTE_IDX_FIRST = 2'd0;   // lands in [31:24]
    localparam logic [1:0] BYTE_IDX_LAST  = 2'd3;   // lands in [7:0]
    localparam int         WORD_BYTES     = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte source, memory write port and status bundle for imem_loader.
// The loader drives through the master modport; the environment uses slave.
interface imem_loader_if #(
    parameter int ADDR_W = 16
) ();
    logic              i_start;
    logic [15:0]       i_num_words;
    logic              i_byte_valid;
    logic [7:0]        i_byte_data;
    logic              o_byte_ready;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_data;
    logic              o_cpu_hold;
    logic              o_busy;
    logic              o_done;
    logic              o_error;
    logic [15:0]       o_words_loaded;

    modport master (
        input  i_start, i_num_words, i_byte_valid, i_byte_data,
        output o_byte_ready, o_mem_we, o_mem_addr, o_mem_data,
        output o_cpu_hold, o_busy, o_done, o_error, o_words_loaded
    );

    modport slave (
        output i_start, i_num_words, i_byte_valid, i_byte_data,
        input  o_byte_ready, o_mem_we, o_mem_addr, o_mem_data,
        input  o_cpu_hold, o_busy, o_done, o_error, o_words_loaded
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte packer: first byte of each group ends up in bits [31:24].
// o_word is the completed word, valid only while o_word_full is high.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_full
);
    logic [1:0]  r_idx;
    logic [23:0] r_shift;

    assign o_word_full = i_accept && (r_idx == BYTE_IDX_LAST);
    assign o_word      = {r_shift, i_byte};

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_idx   <= BYTE_IDX_FIRST;
            r_shift <= '0;
        end else if (i_clear) begin
            r_idx   <= BYTE_IDX_FIRST;
        end else if (i_accept) begin
            r_idx   <= r_idx + 2'd1;
            r_shift <= {r_shift[15:0], i_byte};
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory as 32-bit words while holding the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 256
) (
    input  logic          i_clock,
    input  logic          i_reset,
    imem_loader_if.master bus
);
    localparam logic [15:0]       MAX_N = 16'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

    state_t            r_state, w_next;
    logic [15:0]       r_num, r_words;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic [15:0]       w_num_clamped;
    logic              w_start, w_accept, w_ready, w_last, w_word_full;
    logic [31:0]       w_word;

    assign w_num_clamped = (bus.i_num_words > MAX_N) ? MAX_N : bus.i_num_words;
    assign w_start  = bus.i_start &&
                      (r_state == IDLE || r_state == DONE || r_state == ERROR);
    assign w_accept = (r_state == RECV) && bus.i_byte_valid;
    assign w_last   = (r_words + 16'd1) == r_num;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_LAST = CHECK;
    logic [7:0] r_csum;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)       r_csum <= '0;
        else if (w_start)  r_csum <= '0;
        else if (w_accept) r_csum <= r_csum ^ bus.i_byte_data;
    end

    assign w_ready     = (r_state == RECV) || (r_state == CHECK);
    assign bus.o_error = (r_state == ERROR);
`else
    localparam state_t S_AFTER_LAST = DONE;
    assign w_ready     = (r_state == RECV);
    assign bus.o_error = 1'b0;
`endif

    byte_packer u_packer (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_clear     (w_start),
        .i_accept    (w_accept),
        .i_byte      (bus.i_byte_data),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE, ERROR:
                if (w_start) w_next = (w_num_clamped == 16'd0) ? S_AFTER_LAST : RECV;
            RECV:
                if (w_word_full) w_next = WRITE;
            WRITE:
                w_next = w_last ? S_AFTER_LAST : RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK:
                if (bus.i_byte_valid) w_next = (bus.i_byte_data == r_csum) ? DONE : ERROR;
`endif
            default:
                w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_num   <= '0;
            r_words <= '0;
            r_addr  <= BASE;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_num   <= w_num_clamped;
                r_words <= '0;
                r_addr  <= BASE;
            end else if (r_state == WRITE) begin
                r_addr  <= r_addr + ADDR_W'(WORD_BYTES);
                r_words <= r_words + 16'd1;
            end
            // latch the whole word so mem_data stays steady while the next one fills
            if (w_word_full) r_data <= w_word;
        end
    end

    assign bus.o_byte_ready   = w_ready;
    assign bus.o_mem_we       = (r_state == WRITE);
    assign bus.o_mem_addr     = r_addr;
    assign bus.o_mem_data     = r_data;
    assign bus.o_busy         = (r_state == RECV) || (r_state == WRITE) || (r_state == CHECK);
    assign bus.o_cpu_hold     = bus.o_busy;
    assign bus.o_done         = (r_state == DONE);
    assign bus.o_words_loaded = r_words;
endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized checks of imem_loader (default build) against a
// word-list model derived from the byte stream.
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    logic [7:0]  stream    [$];
    logic [15:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];

    imem_loader_if #(.ADDR_W(16)) bus ();

    imem_loader #(.ADDR_W(16), .BASE_ADDR(0), .MAX_WORDS(256)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && bus.o_mem_we) begin
            wr_addr_q.push_back(bus.o_mem_addr);
            wr_data_q.push_back(bus.o_mem_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_ready"}, bus.o_byte_ready, 0);
        check({tag, "_mem_we"}, bus.o_mem_we, 0);
        check({tag, "_cpu_hold"}, bus.o_cpu_hold, 0);
        check({tag, "_busy"}, bus.o_busy, 0);
        check({tag, "_done"}, bus.o_done, 0);
        check({tag, "_error"}, bus.o_error, 0);
        check({tag, "_mem_addr"}, bus.o_mem_addr, 0);
        check({tag, "_mem_data"}, bus.o_mem_data, 0);
        check({tag, "_words"}, bus.o_words_loaded, 0);
    endtask

    task automatic fill_random(input int nbytes);
        stream.delete();
        for (int i = 0; i < nbytes; i++) stream.push_back(8'($urandom));
    endtask

    // mode 0: valid always high, 1: valid every other cycle, 2: random valid.
    // abort_at >= 0 stops feeding after that many accepted bytes and skips checks.
    task automatic run_load(input string tag, input int n_req, input int mode, input int abort_at);
        int n, nb, idx, guard, budget, start_cyc;
        bit v, rdy, hold_ok;
        logic [31:0] exp_word;
        n = (n_req > 256) ? 256 : n_req;
        nb = 4 * n;
        budget = 20 * nb + 50;
        idx = 0;
        guard = 0;
        hold_ok = 1'b1;
        @(negedge clk);
        wr_addr_q.delete();
        wr_data_q.delete();
        bus.i_start = 1'b1;
        bus.i_num_words = 16'(n_req);
        start_cyc = cyc;
        @(negedge clk);
        bus.i_start = 1'b0;
        while (idx < nb && guard < budget) begin
            if (abort_at >= 0 && idx == abort_at) break;
            case (mode)
                0:       v = 1'b1;
                1:       v = (guard % 2) == 0;
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.i_byte_valid = v;
            bus.i_byte_data = v ? stream[idx] : 8'($urandom);
            rdy = bus.o_byte_ready;
            if (!bus.o_cpu_hold) hold_ok = 1'b0;
            @(posedge clk);
            if (v && rdy) idx++;
            @(negedge clk);
            guard++;
        end
        bus.i_byte_valid = 1'b0;
        if (abort_at >= 0) return;
        while (!bus.o_done && guard < budget) begin
            if (!bus.o_cpu_hold) hold_ok = 1'b0;
            @(negedge clk);
            guard++;
        end
        check({tag, "_done_timeout"}, guard < budget, 1);
        check({tag, "_done"}, bus.o_done, 1);
        if (mode == 0) check({tag, "_done_latency"}, cyc - start_cyc, 5 * n + 1);
        check({tag, "_hold_during_load"}, hold_ok, 1);
        check({tag, "_cpu_hold_end"}, bus.o_cpu_hold, 0);
        check({tag, "_busy_end"}, bus.o_busy, 0);
        check({tag, "_error_end"}, bus.o_error, 0);
        check({tag, "_words_loaded"}, bus.o_words_loaded, n);
        check({tag, "_write_count"}, wr_addr_q.size(), n);
        check({tag, "_addr_end"}, bus.o_mem_addr, 16'(4 * n));
        for (int w = 0; w < n && w < wr_addr_q.size(); w++) begin
            exp_word = {stream[4*w], stream[4*w+1], stream[4*w+2], stream[4*w+3]};
            check($sformatf("%s_wr%0d_addr", tag, w), wr_addr_q[w], 16'(4 * w));
            check($sformatf("%s_wr%0d_data", tag, w), wr_data_q[w], exp_word);
        end
    endtask

    initial begin
        bit rdy_seen;
        bus.i_start = 1'b0;
        bus.i_num_words = '0;
        bus.i_byte_valid = 1'b0;
        bus.i_byte_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle");

        stream = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h20, 8'h02, 8'h00, 8'h05};
        run_load("two_words", 2, 0, -1);
        if (wr_data_q.size() == 2) begin
            check("two_words_w0_lit", wr_data_q[0], 32'h8C010004);
            check("two_words_w1_lit", wr_data_q[1], 32'h20020005);
        end

        run_load("toggle_valid", 2, 1, -1);

        run_load("zero_words", 0, 0, -1);
        rdy_seen = 1'b0;
        bus.i_byte_valid = 1'b1;
        bus.i_byte_data = 8'h00;
        repeat (4) begin
            if (bus.o_byte_ready) rdy_seen = 1'b1;
            @(negedge clk);
        end
        bus.i_byte_valid = 1'b0;
        check("zero_words_ready_never", rdy_seen, 0);
        check("zero_words_no_write", wr_addr_q.size(), 0);
        check("zero_words_done_stays", bus.o_done, 1);

        fill_random(1024);
        run_load("clamp_300", 300, 0, -1);
        if (wr_addr_q.size() > 0)
            check("clamp_300_last_addr", wr_addr_q[wr_addr_q.size()-1], 16'h03FC);

        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, 6);
            fill_random(4 * n);
            run_load($sformatf("rand%0d", r), n, 2, -1);
        end

        fill_random(12);
        run_load("abort", 3, 0, 2);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        fill_random(8);
        run_load("after_rst", 2, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
